fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end. Generates sequential fetch addresses from an internal PC and issues them to instruction memory over a valid/ready request channel. Responses are held in a DEPTH-entry FWFT queue and handed to decode over a valid/ready output channel. Supports branch redirect, pipeline flush and discard of in-flight responses; sits between the program memory port and decode.

Parameters:
INSTR_WIDTH, 16, instruction word width
ADDR_WIDTH, 13, fetch address width; PC wraps modulo 2^ADDR_WIDTH
DEPTH, 8, queue entries; power of 2, >=2
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
pon_rst_n_i  in  1  asynchronous active-low reset
fetch_enable  in  1  permits new memory requests
redirect_valid  in  1  branch taken; load PC from redirect_addr
redirect_addr  in  ADDR_WIDTH  branch target
flush  in  1  clear queue, keep PC
mem_req_valid  out  1  request valid
mem_req_addr  out  ADDR_WIDTH  request address
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  response valid, one per accepted request, latency >=1
mem_rsp_data  in  INSTR_WIDTH  instruction word
out_valid  out  1  queue non-empty
out_instr  out  INSTR_WIDTH  head instruction
out_addr  out  ADDR_WIDTH  head address
out_ready  in  1  decode consumes head
queue_count  out  clog2(DEPTH)+1  occupied entries
fetch_stall  out  1  queue full and fetch_enable high

Behaviour:
- Reset (async, any time): PC=RESET_PC, queue empty, state IDLE, drop flag 0; all outputs 0 (out_instr/out_addr 0, queue_count 0). Reset mid-transaction abandons it; the bench must not return the stale response.
- States: IDLE, REQ, WAIT.
- IDLE -> REQ when fetch_enable && queue_count+pending < DEPTH (pending = 1 in WAIT, else 0). Otherwise stay.
- REQ: mem_req_valid=1, mem_req_addr=PC; address stable while valid && !ready. On accept -> WAIT, latch address.
- WAIT: on mem_rsp_valid, if drop=0, push {data, latched addr}, PC<=PC+1 (wrap); -> IDLE. If drop=1, discard, clear drop, -> IDLE. The next request is issued no earlier than the cycle after the response (one outstanding request max).
- Output: FWFT; out_valid=!empty; out_instr/out_addr show head combinationally from storage; pop on out_valid && out_ready.
- Push and pop in the same cycle: both happen; count unchanged. Head/tail pointers wrap modulo DEPTH.
- Full: no new request is issued; fetch_stall=1 while count==DEPTH && fetch_enable.
- Redirect (highest priority with flush): queue cleared next cycle, any same-cycle pop or push ignored, PC<=redirect_addr. In WAIT, or in REQ with handshake that cycle -> drop=1, state WAIT. In REQ without handshake -> request withdrawn, state IDLE.
- Flush: same as redirect but PC unchanged, except that PC<=address of the discarded in-flight request if one exists.
- Redirect and flush together: redirect wins.
- fetch_enable low: an in-progress REQ/WAIT completes; no new request.
- mem_rsp_valid outside WAIT: ignored.

Test Plan:
- Reset, fetch_enable=1, memory ready, 1-cycle latency, data=addr^16'hABC0 -> out_addr 0,1,2… in order, out_instr matches, no gaps.
- out_ready=0, DEPTH=8 -> queue_count reaches 8, fetch_stall=1, no mem_req_valid. Then out_ready=1 for 1 cycle -> count 7, one new request to addr 8.
- mem_req_ready held low 5 cycles -> mem_req_addr stable at request value, accepted on cycle 6, single response queued.
- Redirect to 13'h1F00 while in WAIT for addr 5 -> addr-5 response discarded, queue empty, next request 13'h1F00.
- PC=13'h1FFF fetch -> next request addr 0 (wrap); pointers wrap after 9 push/pop pairs with data intact.
- Assert pon_rst_n_i low asynchronously with 4 queued entries mid-WAIT -> all outputs 0 immediately, first request after release to RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch front end. An internal PC drives sequential requests to
// instruction memory (one outstanding at a time); responses land in a
// DEPTH-entry first-word-fall-through queue that feeds decode.
//
// Ports
//   clk             rising-edge clock
//   pon_rst_n_i     asynchronous active-low reset
//   fetch_enable    permits new memory requests
//   redirect_valid  branch taken: clear queue, load PC from redirect_addr
//   redirect_addr   branch target
//   flush           clear queue, keep PC (rewinds to a discarded in-flight fetch)
//   mem_req_*       request channel to memory (valid/ready, address)
//   mem_rsp_*       response channel from memory (one per accepted request)
//   out_*           head of queue to decode (valid/ready, instruction, address)
//   queue_count     occupied entries
//   fetch_stall     queue full while fetch_enable is high
module fetch_queue_unit #(
  parameter int unsigned            INSTR_WIDTH = 16,
  parameter int unsigned            ADDR_WIDTH  = 13,
  parameter int unsigned            DEPTH       = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                      clk,
  input  logic                      pon_rst_n_i,
  input  logic                      fetch_enable,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_addr,
  input  logic                      flush,
  output logic                      mem_req_valid,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]    mem_rsp_data,
  output logic                      out_valid,
  output logic [INSTR_WIDTH-1:0]    out_instr,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    queue_count,
  output logic                      fetch_stall
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic                    r_req_valid;
  logic [ADDR_WIDTH-1:0]   r_req_addr;
  logic [ADDR_WIDTH-1:0]   r_lat_addr;
  logic                    r_drop;

  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;
  logic [INSTR_WIDTH-1:0]  r_instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_addr_mem  [DEPTH];

  logic w_kill;
  logic w_push;
  logic w_pop;
  logic w_space;
  logic w_pending;

  // Redirect and flush share every queue/FSM effect except the PC update.
  assign w_kill    = redirect_valid | flush;
  assign w_pending = (r_state == StWait);
  // Room must exist for the response of the request about to be issued.
  assign w_space   = (r_count + CNT_W'(w_pending)) < FULL_CNT;
  assign w_push    = (r_state == StWait) & mem_rsp_valid & ~r_drop & ~w_kill;
  assign w_pop     = out_valid & out_ready & ~w_kill;

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign out_valid     = (r_count != '0);
  assign out_instr     = out_valid ? r_instr_mem[r_head] : '0;
  assign out_addr      = out_valid ? r_addr_mem[r_head]  : '0;
  assign queue_count   = r_count;
  assign fetch_stall   = (r_count == FULL_CNT) & fetch_enable;

  // Fetch FSM. Request valid/address are registered outputs; the address is
  // held at zero outside StReq.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_lat_addr  <= '0;
      r_drop      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_kill) begin
            // Stay idle this cycle so the new PC is the one issued next.
            if (redirect_valid) r_pc <= redirect_addr;
          end else if (fetch_enable && w_space) begin
            r_state     <= StReq;
            r_req_valid <= 1'b1;
            r_req_addr  <= r_pc;
          end
        end

        StReq: begin
          if (w_kill) begin
            if (redirect_valid) r_pc <= redirect_addr;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            if (mem_req_ready) begin
              // Accepted anyway: a response is owed and must be thrown away.
              r_state    <= StWait;
              r_drop     <= 1'b1;
              r_lat_addr <= r_req_addr;
            end else begin
              r_state <= StIdle;
            end
          end else if (mem_req_ready) begin
            r_state     <= StWait;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_lat_addr  <= r_req_addr;
          end
        end

        StWait: begin
          if (mem_rsp_valid) begin
            // The owed response arrives: nothing is outstanding any more, so
            // even a same-cycle kill returns to idle rather than waiting again.
            r_state <= StIdle;
            r_drop  <= 1'b0;
            if (w_kill) begin
              if (redirect_valid)  r_pc <= redirect_addr;
              else if (!r_drop)    r_pc <= r_lat_addr;
            end else if (!r_drop) begin
              r_pc <= r_pc + ADDR_WIDTH'(1);
            end
          end else if (w_kill) begin
            r_drop <= 1'b1;
            // Flush refetches the live in-flight address; a fetch already
            // marked for drop belongs to an abandoned stream.
            if (redirect_valid)  r_pc <= redirect_addr;
            else if (!r_drop)    r_pc <= r_lat_addr;
          end
        end

        default: begin
          r_state     <= StIdle;
          r_req_valid <= 1'b0;
          r_req_addr  <= '0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_kill) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_tail] <= mem_rsp_data;
      r_addr_mem[r_tail]  <= r_lat_addr;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  localparam int unsigned IW    = 16;
  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clk = 1'b0;
  logic          pon_rst_n_i;
  logic          fetch_enable;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          flush;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [IW-1:0] mem_rsp_data;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_addr;
  logic          out_ready;
  logic [CW-1:0] queue_count;
  logic          fetch_stall;

  fetch_queue_unit #(
    .INSTR_WIDTH (IW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk            (clk),
    .pon_rst_n_i    (pon_rst_n_i),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_addr       (out_addr),
    .out_ready      (out_ready),
    .queue_count    (queue_count),
    .fetch_stall    (fetch_stall)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t s_e;
  exp_t m_e;

  // Stimulus knobs (percent probabilities) and one-shot overrides.
  int kn_fe = 0, kn_ordy = 0, kn_mrdy = 0, kn_redir = 0, kn_flush = 0, kn_spur = 0;
  int kn_lat_min = 1, kn_lat_max = 1;
  bit one_redir = 0, one_ordy = 0;
  logic [AW-1:0] one_addr = '0;

  // Memory responder / reference model state.
  bit            os_valid = 0, os_discard = 0;
  int            os_wait = 0;
  logic [AW-1:0] os_addr = '0;
  logic [AW-1:0] model_pc = RESET_PC;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  bit            s_kill, s_hs, s_rsp;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return IW'(a) ^ IW'(16'hABC0);
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    int n = 0;
    ok = 0;
    while (n < budget && !ok) begin
      if (mem_req_valid) ok = 1;
      else begin
        cyc(1);
        n++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_valid"}, mem_req_valid, 0);
    check({tag, "_req_addr"},  mem_req_addr,  0);
    check({tag, "_out_valid"}, out_valid,     0);
    check({tag, "_out_instr"}, out_instr,     0);
    check({tag, "_out_addr"},  out_addr,      0);
    check({tag, "_count"},     queue_count,   0);
    check({tag, "_stall"},     fetch_stall,   0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    pon_rst_n_i = 1'b0;
    #1;
    check_zero("rst");
    cyc(3);
    #2;
    pon_rst_n_i = 1'b1;
    cyc(1);
  endtask

  // Stimulus + memory responder + reference model. Inputs change on the
  // falling edge; the model predicts what the next rising edge will do.
  initial begin
    fetch_enable = 0; out_ready = 0; mem_req_ready = 0; redirect_valid = 0;
    redirect_addr = '0; flush = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!pon_rst_n_i) begin
        fetch_enable = 0; out_ready = 0; mem_req_ready = 0; redirect_valid = 0;
        flush = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        exp_q.delete();
        os_valid = 0; os_discard = 0; model_pc = RESET_PC; prev_stall = 0;
        one_redir = 0; one_ordy = 0;
      end else begin
        fetch_enable   = pct(kn_fe);
        out_ready      = one_ordy || pct(kn_ordy);
        one_ordy       = 0;
        mem_req_ready  = pct(kn_mrdy);
        redirect_valid = one_redir || pct(kn_redir);
        redirect_addr  = one_redir ? one_addr : AW'($urandom);
        one_redir      = 0;
        flush          = pct(kn_flush);
        s_kill         = redirect_valid || flush;

        if (prev_stall) begin
          check("req_hold_valid", mem_req_valid, 1);
          check("req_hold_addr", mem_req_addr, prev_addr);
        end
        s_hs = mem_req_valid && mem_req_ready;
        if (s_hs) check("req_addr", mem_req_addr, model_pc);

        s_rsp         = os_valid && (os_wait == 0);
        mem_rsp_valid = s_rsp;
        mem_rsp_data  = s_rsp ? mem_word(os_addr) : IW'($urandom);
        // Responses with nothing outstanding must be ignored by the DUT.
        if (!os_valid && pct(kn_spur)) mem_rsp_valid = 1;

        if (s_rsp) begin
          if (!s_kill && !os_discard) begin
            s_e.addr  = os_addr;
            s_e.instr = mem_word(os_addr);
            exp_q.push_back(s_e);
            model_pc = os_addr + 1'b1;
          end
          os_valid = 0;
        end else if (os_valid) begin
          os_wait--;
          if (s_kill) os_discard = 1;
        end
        if (s_kill) exp_q.delete();
        if (redirect_valid) model_pc = redirect_addr;
        if (s_hs) begin
          os_valid   = 1;
          os_addr    = mem_req_addr;
          os_discard = s_kill;
          os_wait    = int'($urandom_range(kn_lat_max - 1, kn_lat_min - 1));
        end
        prev_stall = mem_req_valid && !mem_req_ready && !s_kill;
        prev_addr  = mem_req_addr;
      end
    end
  end

  // Monitor: every handshake on the output channel pops the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (pon_rst_n_i && out_valid && out_ready && !redirect_valid && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got addr %0h instr %0h expected none", out_addr,
                   out_instr);
        end else begin
          m_e = exp_q.pop_front();
          check("out_addr", out_addr, m_e.addr);
          check("out_instr", out_instr, m_e.instr);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            ok;
    int            n;
    logic [AW-1:0] a0;

    pon_rst_n_i = 1'b1;
    #2;
    pon_rst_n_i = 1'b0;
    #2;
    check_zero("por");
    cyc(2);
    #2;
    pon_rst_n_i = 1'b1;

    // Streaming with 1-cycle latency; pointers wrap several times.
    kn_fe = 100; kn_ordy = 100; kn_mrdy = 100; kn_lat_min = 1; kn_lat_max = 1;
    wait_req(40, ok);
    check("first_req_seen", ok, 1);
    check("first_req_addr", mem_req_addr, RESET_PC);
    cyc(60);

    // Fill to full, then release exactly one entry.
    kn_ordy = 0;
    do_reset();
    n = 0; ok = 0;
    while (n < 300 && !ok) begin
      if (queue_count == CW'(DEPTH)) ok = 1;
      else begin cyc(1); n++; end
    end
    check("fill_reached", ok, 1);
    cyc(3);
    check("full_stall", fetch_stall, 1);
    check("full_no_req", mem_req_valid, 0);
    check("full_count", queue_count, DEPTH);
    one_ordy = 1;
    cyc(1);
    check("one_pop_count", queue_count, DEPTH - 1);
    check("one_pop_stall", fetch_stall, 0);
    wait_req(20, ok);
    check("refill_req_seen", ok, 1);
    check("refill_req_addr", mem_req_addr, RESET_PC + AW'(DEPTH));

    // Memory back-pressure: request address must hold for 5 cycles.
    kn_ordy = 100; kn_fe = 0;
    cyc(40);
    check("drain_count", queue_count, 0);
    kn_ordy = 0; kn_mrdy = 0; kn_fe = 100;
    wait_req(20, ok);
    check("bp_req_seen", ok, 1);
    kn_fe = 0;
    a0 = model_pc;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", mem_req_valid, 1);
      check("bp_addr", mem_req_addr, a0);
      cyc(1);
    end
    kn_mrdy = 100;
    cyc(8);
    check("bp_single_count", queue_count, 1);
    check("bp_no_more_req", mem_req_valid, 0);
    check("bp_head_addr", out_addr, a0);
    kn_ordy = 100;
    cyc(5);

    // Redirect while waiting on the response for address 5.
    kn_ordy = 0; kn_lat_min = 4; kn_lat_max = 4;
    do_reset();
    kn_fe = 100;
    n = 0; ok = 0;
    while (n < 300 && !ok) begin
      if (mem_req_valid && mem_req_addr == AW'(5)) ok = 1;
      else begin cyc(1); n++; end
    end
    check("addr5_req_seen", ok, 1);
    cyc(1);
    one_addr = 13'h1F00;
    one_redir = 1;
    cyc(1);
    check("redir_count", queue_count, 0);
    check("redir_out_valid", out_valid, 0);
    wait_req(30, ok);
    check("redir_req_seen", ok, 1);
    check("redir_req_addr", mem_req_addr, 13'h1F00);

    // PC wrap from 0x1FFF to 0.
    kn_ordy = 100; kn_lat_min = 1; kn_lat_max = 1;
    one_addr = 13'h1FFE;
    one_redir = 1;
    cyc(1);
    n = 0; ok = 0;
    while (n < 100 && !ok) begin
      if (mem_req_valid && mem_req_addr == 13'h1FFF) ok = 1;
      else begin cyc(1); n++; end
    end
    check("req_1fff_seen", ok, 1);
    cyc(1);
    wait_req(20, ok);
    check("wrap_req_seen", ok, 1);
    check("wrap_req_addr", mem_req_addr, 0);

    // Asynchronous reset with 4 queued entries and a request in flight.
    kn_ordy = 0; kn_lat_min = 6; kn_lat_max = 6;
    n = 0; ok = 0;
    while (n < 300 && !ok) begin
      if (queue_count == CW'(4) && os_valid) ok = 1;
      else begin cyc(1); n++; end
    end
    check("four_queued_wait", ok, 1);
    #2;
    pon_rst_n_i = 1'b0;
    #1;
    check_zero("async");
    cyc(2);
    #2;
    pon_rst_n_i = 1'b1;
    kn_lat_min = 1; kn_lat_max = 4;
    wait_req(20, ok);
    check("post_rst_req_seen", ok, 1);
    check("post_rst_req_addr", mem_req_addr, RESET_PC);

    // Randomised soak.
    kn_fe = 85; kn_ordy = 60; kn_mrdy = 60; kn_redir = 2; kn_flush = 3; kn_spur = 10;
    cyc(4000);

    // Drain and confirm nothing was lost.
    kn_fe = 0; kn_redir = 0; kn_flush = 0; kn_spur = 0; kn_ordy = 100; kn_mrdy = 100;
    cyc(40);
    check("final_scoreboard_left", exp_q.size(), 0);
    check("final_count", queue_count, 0);
    check("final_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
